// File: rtl/ex_muldiv_unit.sv
// Iterative 32-bit multiply/divide unit for the EX stage; owns HI/LO and
// stalls the pipeline while a 32-iteration shift-add or restoring divide runs.
module ex_muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        md_start_Ex,
  input  logic [2:0]  md_op_Ex,
  input  logic        rd_hilo_Ex,
  input  logic        cancel_Ex,
  input  logic [31:0] busA_Ex,
  input  logic [31:0] busB_Ex,
  output logic [31:0] hi_Ex,
  output logic [31:0] lo_Ex,
  output logic        busy_Ex,
  output logic        md_stall
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state_q;
  logic [4:0]  count_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] accHi_q, accLo_q, opnd_q, origA_q;
  logic        isDiv_q, negRes_q, negRem_q, divZero_q;

  logic        isSigned, aNeg, bNeg;
  logic [31:0] absA, absB;
  logic [32:0] mulSum;
  logic [32:0] divShift;
  logic [33:0] divDiff;
  logic        divOk;
  logic [31:0] stepHi, stepLo;
  logic [63:0] product;
  logic [31:0] fixHi, fixLo;

  always_comb begin
    isSigned = ~md_op_Ex[0];
    aNeg     = isSigned & busA_Ex[31];
    bNeg     = isSigned & busB_Ex[31];
    absA     = aNeg ? (32'd0 - busA_Ex) : busA_Ex;
    absB     = bNeg ? (32'd0 - busB_Ex) : busB_Ex;
  end

  // One iteration: multiply adds opnd into the upper half and shifts right;
  // divide shifts the dividend into the partial remainder and tries a subtract.
  always_comb begin
    mulSum   = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, opnd_q} : 33'd0);
    divShift = {accHi_q, accLo_q[31]};
    divDiff  = {1'b0, divShift} - {2'b00, opnd_q};
    divOk    = ~divDiff[33];
    stepHi   = mulSum[32:1];
    stepLo   = {mulSum[0], accLo_q[31:1]};
    if (isDiv_q) begin
      stepHi = divOk ? divDiff[31:0] : divShift[31:0];
      stepLo = {accLo_q[30:0], divOk};
    end
  end

  always_comb begin
    product = {accHi_q, accLo_q};
    if (negRes_q) product = 64'd0 - product;
    fixHi = product[63:32];
    fixLo = product[31:0];
    if (isDiv_q) begin
      fixLo = negRes_q ? (32'd0 - accLo_q) : accLo_q;
      fixHi = negRem_q ? (32'd0 - accHi_q) : accHi_q;
      if (divZero_q) begin
        fixLo = 32'hFFFF_FFFF;
        fixHi = origA_q;
      end
    end
  end

  // Cancel only aborts CALC; once in FIX the result is committed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= 5'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      accHi_q   <= 32'd0;
      accLo_q   <= 32'd0;
      opnd_q    <= 32'd0;
      origA_q   <= 32'd0;
      isDiv_q   <= 1'b0;
      negRes_q  <= 1'b0;
      negRem_q  <= 1'b0;
      divZero_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (md_start_Ex && !cancel_Ex) begin
            case (md_op_Ex)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                accHi_q   <= 32'd0;
                accLo_q   <= absA;
                opnd_q    <= absB;
                origA_q   <= busA_Ex;
                isDiv_q   <= md_op_Ex[1];
                negRes_q  <= aNeg ^ bNeg;
                negRem_q  <= aNeg;
                divZero_q <= (busB_Ex == 32'd0);
                count_q   <= 5'd0;
                state_q   <= CALC;
              end
              3'b100:  hi_q <= busA_Ex;
              3'b101:  lo_q <= busA_Ex;
              default: ;
            endcase
          end
        end
        CALC: begin
          if (cancel_Ex) begin
            state_q <= IDLE;
            count_q <= 5'd0;
          end else begin
            accHi_q <= stepHi;
            accLo_q <= stepLo;
            count_q <= count_q + 5'd1;
            if (count_q == 5'd31) state_q <= FIX;
          end
        end
        FIX: begin
          hi_q    <= fixHi;
          lo_q    <= fixLo;
          count_q <= 5'd0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hi_Ex    = hi_q;
  assign lo_Ex    = lo_q;
  assign busy_Ex  = (state_q != IDLE);
  assign md_stall = busy_Ex & (md_start_Ex | rd_hilo_Ex);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corners plus random ops
// compared against an arithmetic HI/LO model.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        md_start_Ex;
  logic [2:0]  md_op_Ex;
  logic        rd_hilo_Ex;
  logic        cancel_Ex;
  logic [31:0] busA_Ex, busB_Ex;
  logic [31:0] hi_Ex, lo_Ex;
  logic        busy_Ex, md_stall;

  int total = 0;
  int bad   = 0;
  logic [31:0] hiM = 32'd0;
  logic [31:0] loM = 32'd0;

  ex_muldiv_unit dut (
    .clk        (clk),
    .rst        (rst),
    .md_start_Ex(md_start_Ex),
    .md_op_Ex   (md_op_Ex),
    .rd_hilo_Ex (rd_hilo_Ex),
    .cancel_Ex  (cancel_Ex),
    .busA_Ex    (busA_Ex),
    .busB_Ex    (busB_Ex),
    .hi_Ex      (hi_Ex),
    .lo_Ex      (lo_Ex),
    .busy_Ex    (busy_Ex),
    .md_stall   (md_stall)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference: HI/LO as the architecture defines them, via plain arithmetic.
  task automatic modelOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint     p;
    logic [63:0] up;
    int         sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'd0: begin p = longint'(sa) * longint'(sb); hiM = p[63:32]; loM = p[31:0]; end
      3'd1: begin up = {32'd0, a} * {32'd0, b}; hiM = up[63:32]; loM = up[31:0]; end
      3'd2: begin
        if (b == 32'd0) begin loM = 32'hFFFF_FFFF; hiM = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin loM = 32'h8000_0000; hiM = 32'd0; end
        else begin loM = sa / sb; hiM = sa % sb; end
      end
      3'd3: begin
        if (b == 32'd0) begin loM = 32'hFFFF_FFFF; hiM = a; end
        else begin loM = a / b; hiM = a % b; end
      end
      3'd4: hiM = a;
      3'd5: loM = a;
      default: ;
    endcase
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    md_start_Ex = 1'b1;
    md_op_Ex    = op;
    busA_Ex     = a;
    busB_Ex     = b;
    @(negedge clk);
    md_start_Ex = 1'b0;
  endtask

  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (busy_Ex && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic runMulDiv(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int cycles;
    applyStimulus(op, a, b);
    waitIdle(cycles);
    modelOp(op, a, b);
    checkOutput({tag, ".busyLen"}, cycles, 32'd33);
    checkOutput({tag, ".hi"}, hi_Ex, hiM);
    checkOutput({tag, ".lo"}, lo_Ex, loM);
  endtask

  initial begin
    int cycles;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    rst = 1'b1; md_start_Ex = 1'b0; md_op_Ex = 3'd0; rd_hilo_Ex = 1'b0;
    cancel_Ex = 1'b0; busA_Ex = 32'd0; busB_Ex = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset.hi", hi_Ex, 32'd0);
    checkOutput("reset.lo", lo_Ex, 32'd0);
    checkOutput("reset.busy", 32'(busy_Ex), 32'd0);

    runMulDiv("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkOutput("multu.hiConst", hi_Ex, 32'hFFFF_FFFE);
    runMulDiv("mult", 3'd0, 32'hFFFF_FFFD, 32'd7);
    checkOutput("mult.loConst", lo_Ex, 32'hFFFF_FFEB);
    runMulDiv("div", 3'd2, 32'hFFFF_FFF9, 32'd2);
    runMulDiv("divu", 3'd3, 32'd100, 32'd7);
    runMulDiv("divu0", 3'd3, 32'h1234_5678, 32'd0);
    runMulDiv("divOvf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);

    // MTLO completes in one edge without going busy
    @(negedge clk);
    md_start_Ex = 1'b1; md_op_Ex = 3'd5; busA_Ex = 32'hCAFE_BABE;
    @(negedge clk);
    md_start_Ex = 1'b0;
    modelOp(3'd5, 32'hCAFE_BABE, 32'd0);
    checkOutput("mtlo.lo", lo_Ex, loM);
    checkOutput("mtlo.busy", 32'(busy_Ex), 32'd0);

    // cancel wins over MTHI in IDLE; no-op opcode does nothing
    @(negedge clk);
    md_start_Ex = 1'b1; md_op_Ex = 3'd4; busA_Ex = 32'h5555_AAAA; cancel_Ex = 1'b1;
    @(negedge clk);
    md_op_Ex = 3'd6; cancel_Ex = 1'b0;
    @(negedge clk);
    md_start_Ex = 1'b0;
    checkOutput("cancelIdle.hi", hi_Ex, hiM);
    checkOutput("nop.busy", 32'(busy_Ex), 32'd0);
    checkOutput("nop.lo", lo_Ex, loM);

    // MFHI waiting on an in-flight multiply
    applyStimulus(3'd0, 32'h0001_2345, 32'hFFF0_0001);
    rd_hilo_Ex = 1'b1;
    cycles = 0;
    while (busy_Ex && cycles < 100) begin
      checkOutput("mfhi.stall", 32'(md_stall), 32'd1);
      cycles++;
      @(negedge clk);
    end
    modelOp(3'd0, 32'h0001_2345, 32'hFFF0_0001);
    checkOutput("mfhi.stallLen", cycles, 32'd33);
    checkOutput("mfhi.stallDrop", 32'(md_stall), 32'd0);
    checkOutput("mfhi.hi", hi_Ex, hiM);
    rd_hilo_Ex = 1'b0;

    // MULT re-presented while DIVU runs, accepted in first IDLE cycle
    applyStimulus(3'd3, 32'hDEAD_BEEF, 32'd13);
    md_start_Ex = 1'b1; md_op_Ex = 3'd0; busA_Ex = 32'h8000_0001; busB_Ex = 32'h7FFF_FFFF;
    cycles = 0;
    while (busy_Ex && cycles < 100) begin
      checkOutput("busyStart.stall", 32'(md_stall), 32'd1);
      cycles++;
      @(negedge clk);
    end
    modelOp(3'd3, 32'hDEAD_BEEF, 32'd13);
    checkOutput("busyStart.divuLo", lo_Ex, loM);
    checkOutput("busyStart.divuHi", hi_Ex, hiM);
    checkOutput("busyStart.idleStall", 32'(md_stall), 32'd0);
    @(negedge clk);
    md_start_Ex = 1'b0;
    checkOutput("busyStart.accepted", 32'(busy_Ex), 32'd1);
    waitIdle(cycles);
    modelOp(3'd0, 32'h8000_0001, 32'h7FFF_FFFF);
    checkOutput("busyStart.multLen", cycles, 32'd33);
    checkOutput("busyStart.multHi", hi_Ex, hiM);
    checkOutput("busyStart.multLo", lo_Ex, loM);

    // cancel at CALC count 10 leaves HI/LO untouched
    applyStimulus(3'd1, 32'h1111_1111, 32'h2222_2222);
    repeat (10) @(negedge clk);
    cancel_Ex = 1'b1;
    @(negedge clk);
    cancel_Ex = 1'b0;
    checkOutput("cancelCalc.busy", 32'(busy_Ex), 32'd0);
    checkOutput("cancelCalc.hi", hi_Ex, hiM);
    checkOutput("cancelCalc.lo", lo_Ex, loM);

    // cancel in FIX is ignored
    applyStimulus(3'd2, 32'h8765_4321, 32'h0000_1234);
    repeat (32) @(negedge clk);
    cancel_Ex = 1'b1;
    @(negedge clk);
    cancel_Ex = 1'b0;
    modelOp(3'd2, 32'h8765_4321, 32'h0000_1234);
    checkOutput("cancelFix.busy", 32'(busy_Ex), 32'd0);
    checkOutput("cancelFix.hi", hi_Ex, hiM);
    checkOutput("cancelFix.lo", lo_Ex, loM);

    // reset mid-CALC
    applyStimulus(3'd0, 32'h0BAD_F00D, 32'h0000_0003);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hiM = 32'd0; loM = 32'd0;
    checkOutput("rstMid.busy", 32'(busy_Ex), 32'd0);
    checkOutput("rstMid.hi", hi_Ex, hiM);
    checkOutput("rstMid.lo", lo_Ex, loM);

    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 4) == 0) ? 32'd0 :
            ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if ($urandom_range(0, 2) == 0) ra = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
      runMulDiv("random", rop, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the latched operands (busA_Ex, busB_Ex) and a decoded mul/div opcode, and owns the architectural HI/LO registers. It also drives a stall back to the ID/EX register and upstream stages while a multi-cycle operation is in flight.

## Interface
- No parameters. Data width is fixed at 32 bits; the iteration count is fixed at 32.
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- md_start_Ex  in  1  EX instruction is a mul/div/MTHI/MTLO operation.
- md_op_Ex  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are no-ops.
- rd_hilo_Ex  in  1  EX instruction reads HI or LO (MFHI/MFLO).
- cancel_Ex  in  1  flush; aborts the in-flight op.
- busA_Ex  in  32  rs operand: multiplicand or dividend; also the MTHI/MTLO source.
- busB_Ex  in  32  rt operand: multiplier or divisor.
- hi_Ex  out  32  HI register (registered).
- lo_Ex  out  32  LO register (registered).
- busy_Ex  out  1  high when state is not IDLE (registered).
- md_stall  out  1  combinational: busy_Ex & (md_start_Ex | rd_hilo_Ex).

## Operation
- **States.**
  - IDLE: waiting for an op.
  - CALC: one iteration per cycle, counter 0..31.
  - FIX: sign correction, then HI/LO write.
- **IDLE transitions.**
  - md_start_Ex=1, md_op in 000–011, cancel_Ex=0: latch |A|, |B|, signs and op. Go to CALC with count=0.
  - md_op 100: HI <= busA_Ex at the next edge; state stays IDLE.
  - md_op 101: LO <= busA_Ex at the next edge; state stays IDLE.
- **Signedness.** MULT and DIV operate on two's-complement absolute values; MULTU and DIVU use the raw operands.
- **Multiply.** Shift-add over 32 iterations, producing a 64-bit product. For MULT, the product is negated in FIX if the operand signs differ. Result: HI=product[63:32], LO=product[31:0].
- **Divide.** Restoring division, one quotient bit per iteration.
  - For DIV, the quotient is negated if the signs differ; the remainder takes the sign of the dividend.
  - LO=quotient, HI=remainder.
- **Divide by zero.** If the original busB_Ex==0 for DIV or DIVU, FIX writes LO=0xFFFFFFFF, HI=original busA_Ex. Latency is unchanged.
- **Overflow case.** DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0x00000000. No trap is raised.
- **CALC transitions.** After count=31, go to FIX. FIX writes HI/LO, then returns to IDLE.
- **Cancel.**
  - cancel_Ex in CALC: next state is IDLE; HI/LO are unchanged.
  - cancel_Ex in FIX: ignored; the op is committed.
  - cancel_Ex in IDLE: overrides md_start_Ex, so nothing is accepted (including MTHI/MTLO).
- **Start while busy.** md_start_Ex is not accepted while busy. md_stall holds the ID/EX register, so the instruction is re-presented and accepted in the first IDLE cycle.
- **Reset.** rst at any time, including mid-op: state=IDLE, count=0, HI=0, LO=0, busy_Ex=0. Reset has priority over every other input.

## Timing
- Op accepted at edge N: busy_Ex is high from after edge N through edge N+33.
  - Edges N+1..N+32: CALC iterations.
  - Edge N+33: FIX writes HI/LO and sets state to IDLE.
  - New hi_Ex/lo_Ex values are visible after edge N+33.
- MTHI/MTLO take 1 cycle; the new value is visible after the accepting edge.
- A back-to-back MFHI after a mul/div stalls until busy_Ex=0, then reads the new value; forwarding is not needed.
- md_stall has no registered delay; it is asserted in the same cycle the EX instruction presents.
- busy_Ex deasserts in the same edge that HI/LO update. A new op can be accepted in the first cycle after that edge.

## Test plan
- **Unsigned multiply and latency.** After reset, MULTU 0xFFFFFFFF x 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001 after edge N+33. busy_Ex is high for exactly 33 cycles.
- **Signed multiply.** MULT 0xFFFFFFFD (-3) x 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- **Division.**
  - DIV 0xFFFFFFF9 (-7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 100 / 7 → LO=0x0000000E, HI=0x00000002.
- **Divide corners.**
  - DIVU 0x12345678 / 0 → LO=0xFFFFFFFF, HI=0x12345678.
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- **Stall behaviour.**
  - rd_hilo_Ex=1 during CALC → md_stall=1 every cycle until busy_Ex drops; the value read afterwards is the new HI.
  - MULT presented while busy → md_stall=1, and it starts in the first IDLE cycle.
  - MTLO 0xCAFEBABE when idle → LO=0xCAFEBABE after 1 edge, busy_Ex stays 0.
- **Abort and reset.**
  - cancel_Ex at CALC count 10 → IDLE next edge; HI/LO keep their prior values.
  - rst asserted mid-CALC → HI=LO=0, busy_Ex=0 after that edge.
  - cancel_Ex in the FIX cycle → result still written.
